// File: rtl/am29520.sv
// Multilevel pipeline register: two banks of DEPTH/2 stages, dual or single pipeline.
// Define AM29520_VALID_EN to add a per-stage valid bit reported on vld.
module am29520 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SW    = $clog2(DEPTH)
) (
  input  logic             cp,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       i,
  input  logic [SW-1:0]    s,
  input  logic             oe_,
  output logic [WIDTH-1:0] y,
  output logic             vld
);

  localparam int unsigned H = DEPTH / 2;

  // Global index k: 0..H-1 is A1..AH, H..DEPTH-1 is B1..BH.
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    case (i)
      2'b10: begin
        stage_d[0] = d;
        for (int unsigned k = 1; k < H; k++) stage_d[k] = stage_q[k-1];
      end
      2'b01: begin
        stage_d[H] = d;
        for (int unsigned k = H + 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
      end
      2'b00: begin
        // B bank feeds A bank; AH drops off the end.
        stage_d[H] = d;
        for (int unsigned k = H + 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
        stage_d[0] = stage_q[DEPTH-1];
        for (int unsigned k = 1; k < H; k++) stage_d[k] = stage_q[k-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge cp) begin
    if (clr) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  logic             in_range;
  logic [WIDTH-1:0] sel;

  assign in_range = (32'(s) < DEPTH);
  assign sel      = in_range ? stage_q[s] : '0;
  assign y        = oe_ ? 'z : sel;

`ifdef AM29520_VALID_EN
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  always_comb begin
    valid_d = valid_q;
    case (i)
      2'b10: begin
        valid_d[0] = 1'b1;
        for (int unsigned k = 1; k < H; k++) valid_d[k] = valid_q[k-1];
      end
      2'b01: begin
        valid_d[H] = 1'b1;
        for (int unsigned k = H + 1; k < DEPTH; k++) valid_d[k] = valid_q[k-1];
      end
      2'b00: begin
        valid_d[H] = 1'b1;
        for (int unsigned k = H + 1; k < DEPTH; k++) valid_d[k] = valid_q[k-1];
        valid_d[0] = valid_q[DEPTH-1];
        for (int unsigned k = 1; k < H; k++) valid_d[k] = valid_q[k-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge cp) begin
    if (clr) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign vld = in_range & valid_q[s];
`else
  assign vld = in_range;
`endif

endmodule

// File: tb/tb_am29520.sv
// Table-driven bench for am29520 (WIDTH=8, DEPTH=4); s=0..3 selects A1, A2, B1, B2.
module tb_am29520;

  logic       cp = 1'b0;
  logic       clr;
  logic [7:0] d;
  logic [1:0] i;
  logic [1:0] s;
  logic       oe_;
  wire  [7:0] y;
  logic       vld;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 cp = ~cp;

  am29520 #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .cp  (cp),
    .clr (clr),
    .d   (d),
    .i   (i),
    .s   (s),
    .oe_ (oe_),
    .y   (y),
    .vld (vld)
  );

  typedef struct {
    string           name;
    logic            clr;
    logic [1:0]      i;
    logic [7:0]      d;
    logic [0:3][7:0] exp;
    logic [0:3]      v;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input logic c, input logic [1:0] ii, input logic [7:0] dd);
    @(negedge cp);
    clr = c;
    i   = ii;
    d   = dd;
    @(posedge cp);
    #1;
    clr = 1'b0;
    i   = 2'b11;
  endtask

  task automatic check_stages(input string name, input logic [0:3][7:0] exp,
                              input logic [0:3] v);
    logic [0:3] ev;
`ifdef AM29520_VALID_EN
    ev = v;
`else
    ev = 4'b1111;
`endif
    oe_ = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      #1;
      n_tests++;
      if (y !== exp[k]) begin
        n_fail++;
        $display("FAIL %s y s=%0d: got %h required %h", name, k, y, exp[k]);
      end
      n_tests++;
      if (vld !== ev[k]) begin
        n_fail++;
        $display("FAIL %s vld s=%0d: got %b required %b", name, k, vld, ev[k]);
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    i   = 2'b11;
    d   = 8'h00;
    s   = 2'd0;
    oe_ = 1'b0;

    //                 name         clr   i      d      A1     A2     B1     B2      vld
    vecs.push_back('{"reset",     1'b1, 2'b00, 8'h99, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000});
    vecs.push_back('{"pipe1",     1'b0, 2'b00, 8'h11, {8'h00, 8'h00, 8'h11, 8'h00}, 4'b0010});
    vecs.push_back('{"pipe2",     1'b0, 2'b00, 8'h22, {8'h00, 8'h00, 8'h22, 8'h11}, 4'b0011});
    vecs.push_back('{"pipe3",     1'b0, 2'b00, 8'h33, {8'h11, 8'h00, 8'h33, 8'h22}, 4'b1011});
    vecs.push_back('{"pipe4",     1'b0, 2'b00, 8'h44, {8'h22, 8'h11, 8'h44, 8'h33}, 4'b1111});
    vecs.push_back('{"pipe5",     1'b0, 2'b00, 8'h55, {8'h33, 8'h22, 8'h55, 8'h44}, 4'b1111});
    vecs.push_back('{"clr_prio",  1'b1, 2'b00, 8'h77, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000});
    vecs.push_back('{"post_clr",  1'b0, 2'b00, 8'h77, {8'h00, 8'h00, 8'h77, 8'h00}, 4'b0010});
    vecs.push_back('{"reset2",    1'b1, 2'b11, 8'h00, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000});
    vecs.push_back('{"ashift1",   1'b0, 2'b10, 8'hA5, {8'hA5, 8'h00, 8'h00, 8'h00}, 4'b1000});
    vecs.push_back('{"bshift1",   1'b0, 2'b01, 8'h5A, {8'hA5, 8'h00, 8'h5A, 8'h00}, 4'b1010});
    vecs.push_back('{"hold1",     1'b0, 2'b11, 8'hFF, {8'hA5, 8'h00, 8'h5A, 8'h00}, 4'b1010});
    vecs.push_back('{"hold2",     1'b0, 2'b11, 8'hFF, {8'hA5, 8'h00, 8'h5A, 8'h00}, 4'b1010});
    vecs.push_back('{"hold3",     1'b0, 2'b11, 8'hFF, {8'hA5, 8'h00, 8'h5A, 8'h00}, 4'b1010});
    vecs.push_back('{"ashift2",   1'b0, 2'b10, 8'hC3, {8'hC3, 8'hA5, 8'h5A, 8'h00}, 4'b1110});
    vecs.push_back('{"bshift2",   1'b0, 2'b01, 8'h3C, {8'hC3, 8'hA5, 8'h3C, 8'h5A}, 4'b1111});
    vecs.push_back('{"pipe_mix",  1'b0, 2'b00, 8'h96, {8'h5A, 8'hC3, 8'h96, 8'h3C}, 4'b1111});

    foreach (vecs[n]) begin
      step(vecs[n].clr, vecs[n].i, vecs[n].d);
      check_stages(vecs[n].name, vecs[n].exp, vecs[n].v);
    end

    // Reset with outputs disabled: every stage must read back as high impedance.
    step(1'b1, 2'b00, 8'hEE);
    oe_ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      #1;
      n_tests++;
      if (y !== 8'hzz) begin
        n_fail++;
        $display("FAIL reset_oe y s=%0d: got %h required zz", k, y);
      end
    end

    // Toggle oe_ between edges; y must follow with no clock.
    step(1'b0, 2'b01, 8'h5A);
    s = 2'd2;
    for (int k = 0; k < 6; k++) begin
      oe_ = k[0];
      #1;
      n_tests++;
      if (oe_ == 1'b0 && y !== 8'h5A) begin
        n_fail++;
        $display("FAIL oe_toggle step %0d: got %h required 5a", k, y);
      end else if (oe_ == 1'b1 && y !== 8'hzz) begin
        n_fail++;
        $display("FAIL oe_toggle step %0d: got %h required zz", k, y);
      end
    end

    // Select changes between edges take effect immediately.
    oe_ = 1'b0;
    s   = 2'd0;
    #1;
    n_tests++;
    if (y !== 8'h00) begin
      n_fail++;
      $display("FAIL s_change A1: got %h required 00", y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
